// File: rtl/afifo_sqrt_rd.sv
// rtl/afifo_sqrt_rd.sv - afifo read-side consumer computing integer square root and remainder
// Pops {enable, radicand} entries, resolves one root bit per clock, hands results out over valid/ready.
module afifo_sqrt_rd #(
    parameter int DWDTH = 9,
    parameter int NBITS = DWDTH - 1,
    parameter int RWDTH = NBITS / 2
) (
    input  logic             rclk_i,
    input  logic             rrst_i,
    input  logic             rempty_i,
    input  logic [DWDTH-1:0] rdata_i,
    output logic             rinc_o,
    output logic [RWDTH-1:0] root_o,
    output logic [RWDTH:0]   rem_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy_o,
    output logic [7:0]       drop_cnt_o
);

    localparam int ITW  = (RWDTH > 1) ? $clog2(RWDTH) : 1;
    localparam int REMW = RWDTH + 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NBITS-1:0]   rad_q,   rad_d;
    logic [REMW-1:0]    acc_q,   acc_d;
    logic [RWDTH-1:0]   part_q,  part_d;
    logic [ITW-1:0]     iter_q,  iter_d;
    logic [RWDTH-1:0]   root_q,  root_d;
    logic [RWDTH:0]     rem_q,   rem_d;
    logic               valid_q, valid_d;
    logic [7:0]         drop_q,  drop_d;

    logic               pop;
    logic [1:0]         pair;
    logic [REMW-1:0]    acc_sh;
    logic [REMW-1:0]    trial;
    logic               take;
    logic [REMW-1:0]    acc_nx;
    logic [RWDTH-1:0]   part_nx;

    assign pop        = (state_q == IDLE) && !rempty_i && !rrst_i;
    assign rinc_o     = pop;
    assign root_o     = root_q;
    assign rem_o      = rem_q;
    assign valid_o    = valid_q;
    assign busy_o     = (state_q != IDLE);
    assign drop_cnt_o = drop_q;

    // One restoring step: bring down the next radicand pair, try subtracting 4*root+1.
    always_comb begin
        pair = 2'b00;
        for (int i = 0; i < RWDTH; i++) begin
            if (iter_q == ITW'(i)) begin
                pair = rad_q[2*i +: 2];
            end
        end
        acc_sh  = (acc_q << 2) | {{(REMW-2){1'b0}}, pair};
        trial   = {1'b0, part_q, 2'b01};
        take    = (acc_sh >= trial);
        acc_nx  = take ? (acc_sh - trial) : acc_sh;
        part_nx = {part_q[RWDTH-2:0], take};
    end

    always_comb begin
        state_d = state_q;
        rad_d   = rad_q;
        acc_d   = acc_q;
        part_d  = part_q;
        iter_d  = iter_q;
        root_d  = root_q;
        rem_d   = rem_q;
        valid_d = valid_q;
        drop_d  = drop_q;

        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    if (rdata_i[DWDTH-1]) begin
                        rad_d   = rdata_i[NBITS-1:0];
                        acc_d   = '0;
                        part_d  = '0;
                        iter_d  = ITW'(RWDTH - 1);
                        state_d = CALC;
                    end else if (drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                    end
                end
            end
            CALC: begin
                acc_d  = acc_nx;
                part_d = part_nx;
                iter_d = iter_q - ITW'(1);
                if (iter_q == '0) begin
                    root_d  = part_nx;
                    rem_d   = acc_nx[RWDTH:0];
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (valid_q && ready_i) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge rclk_i) begin
        if (rrst_i) begin
            state_q <= IDLE;
            rad_q   <= '0;
            acc_q   <= '0;
            part_q  <= '0;
            iter_q  <= '0;
            root_q  <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            rad_q   <= rad_d;
            acc_q   <= acc_d;
            part_q  <= part_d;
            iter_q  <= iter_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_afifo_sqrt_rd.sv
// tb/tb_afifo_sqrt_rd.sv - directed self-checking bench for afifo_sqrt_rd
module tb_afifo_sqrt_rd;

    localparam int DWDTH = 9;
    localparam int RWDTH = 4;

    logic             rclk_i = 1'b0;
    logic             rrst_i = 1'b1;
    logic             rempty_i = 1'b1;
    logic [DWDTH-1:0] rdata_i = '0;
    logic             ready_i = 1'b0;
    logic             rinc_o;
    logic [RWDTH-1:0] root_o;
    logic [RWDTH:0]   rem_o;
    logic             valid_o;
    logic             busy_o;
    logic [7:0]       drop_cnt_o;

    afifo_sqrt_rd #(.DWDTH(DWDTH)) dut (
        .rclk_i     (rclk_i),
        .rrst_i     (rrst_i),
        .rempty_i   (rempty_i),
        .rdata_i    (rdata_i),
        .rinc_o     (rinc_o),
        .root_o     (root_o),
        .rem_o      (rem_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .busy_o     (busy_o),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 rclk_i = ~rclk_i;

    typedef struct {
        int root;
        int rem;
        int cyc;
    } res_t;

    logic [DWDTH-1:0] fifo[$];
    res_t             res[$];
    int               pops = 0;
    int               cyc = 0;
    int               n_checks = 0;
    int               n_pass = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic void refresh();
        rempty_i = (fifo.size() == 0);
        rdata_i  = (fifo.size() != 0) ? fifo[0] : '0;
    endfunction

    // afifo model: pop decided at the edge, visible 1 time unit later
    always @(posedge rclk_i) begin
        logic do_pop;
        do_pop = rinc_o;
        cyc = cyc + 1;
        #1;
        if (do_pop && fifo.size() != 0) begin
            void'(fifo.pop_front());
            pops++;
        end
        refresh();
    end

    always @(negedge rclk_i) begin
        if (!rrst_i && valid_o && ready_i) begin
            res.push_back('{int'(root_o), int'(rem_o), cyc});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge rclk_i);
            #2;
        end
    endtask

    task automatic push(input logic en, input logic [7:0] rad);
        fifo.push_back({en, rad});
        refresh();
        #1;
    endtask

    task automatic wait_results(input int n, input int budget);
        int k;
        k = 0;
        while (res.size() < n && k < budget) begin
            step(1);
            k++;
        end
        check("result_count", res.size(), n);
    endtask

    task automatic do_reset();
        rrst_i  = 1'b1;
        ready_i = 1'b0;
        fifo.delete();
        refresh();
        step(2);
        push(1'b1, 8'hFF);
        check("rst_rinc_forced0", rinc_o, 0);
        fifo.delete();
        refresh();
        check("rst_root", root_o, 0);
        check("rst_rem", rem_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_drop", drop_cnt_o, 0);
        check("rst_busy", busy_o, 0);
        rrst_i = 1'b0;
        pops = 0;
        res.delete();
        step(1);
    endtask

    initial begin
        do_reset();

        // single 200 -> (14,4), latency 4 after pop
        push(1'b1, 8'd200);
        check("t1_rinc_pre", rinc_o, 1);
        step(1);
        check("t1_rinc_after", rinc_o, 0);
        check("t1_busy", busy_o, 1);
        check("t1_pops", pops, 1);
        step(3);
        check("t1_valid_early", valid_o, 0);
        step(1);
        check("t1_valid", valid_o, 1);
        check("t1_root", root_o, 14);
        check("t1_rem", rem_o, 4);
        check("t1_busy_done", busy_o, 1);
        ready_i = 1'b1;
        step(1);
        check("t1_valid_clr", valid_o, 0);
        check("t1_busy_clr", busy_o, 0);
        check("t1_nres", res.size(), 1);

        // back-to-back with ready high
        res.delete();
        pops = 0;
        push(1'b1, 8'd255);
        push(1'b1, 8'd0);
        push(1'b1, 8'd144);
        push(1'b1, 8'd1);
        wait_results(4, 60);
        if (res.size() == 4) begin
            check("t2_root0", res[0].root, 15);
            check("t2_rem0", res[0].rem, 30);
            check("t2_root1", res[1].root, 0);
            check("t2_rem1", res[1].rem, 0);
            check("t2_root2", res[2].root, 12);
            check("t2_rem2", res[2].rem, 0);
            check("t2_root3", res[3].root, 1);
            check("t2_rem3", res[3].rem, 0);
            for (int i = 1; i < 4; i++) check("t2_spacing", res[i].cyc - res[i-1].cyc, 6);
        end
        check("t2_pops", pops, 4);

        // backpressure: 99 -> (9,18) held while ready low
        ready_i = 1'b0;
        res.delete();
        pops = 0;
        push(1'b1, 8'd99);
        push(1'b1, 8'd4);
        step(5);
        check("t3_valid", valid_o, 1);
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("t3_hold_valid", valid_o, 1);
            check("t3_hold_root", root_o, 9);
            check("t3_hold_rem", rem_o, 18);
            check("t3_no_pop", pops, 1);
        end
        ready_i = 1'b1;
        step(1);
        check("t3_handshake", valid_o, 0);
        check("t3_nres", res.size(), 1);
        wait_results(2, 20);
        if (res.size() == 2) begin
            check("t3_root_next", res[1].root, 2);
            check("t3_rem_next", res[1].rem, 0);
        end
        check("t3_pops", pops, 2);

        // three drops then 16 -> (4,0)
        res.delete();
        pops = 0;
        push(1'b0, 8'hA5);
        push(1'b0, 8'h00);
        push(1'b0, 8'hFF);
        push(1'b1, 8'd16);
        check("t4_rinc0", rinc_o, 1);
        check("t4_drop0", drop_cnt_o, 0);
        for (int i = 1; i <= 3; i++) begin
            step(1);
            check("t4_rinc", rinc_o, 1);
            check("t4_drop", drop_cnt_o, i);
        end
        wait_results(1, 20);
        if (res.size() == 1) begin
            check("t4_root", res[0].root, 4);
            check("t4_rem", res[0].rem, 0);
        end
        check("t4_pops", pops, 4);

        // drop counter saturation
        do_reset();
        ready_i = 1'b1;
        for (int i = 0; i < 260; i++) fifo.push_back({1'b0, 8'(i)});
        refresh();
        step(254);
        check("t5_drop254", drop_cnt_o, 254);
        step(1);
        check("t5_drop255", drop_cnt_o, 255);
        step(10);
        check("t5_drop_sat", drop_cnt_o, 255);
        check("t5_pops", pops, 260);
        check("t5_nres", res.size(), 0);

        // reset in the 2nd CALC cycle of 50, then 49 -> (7,0)
        do_reset();
        ready_i = 1'b1;
        push(1'b1, 8'd50);
        step(2);
        rrst_i = 1'b1;
        step(1);
        rrst_i = 1'b0;
        check("t6_busy", busy_o, 0);
        check("t6_valid", valid_o, 0);
        step(6);
        check("t6_valid_late", valid_o, 0);
        check("t6_nres", res.size(), 0);
        push(1'b1, 8'd49);
        wait_results(1, 20);
        if (res.size() == 1) begin
            check("t6_root", res[0].root, 7);
            check("t6_rem", res[0].rem, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
